// File: rtl/pmu_pkg.sv
// Shared definitions for the multi-counter performance-monitor unit:
// register map, control/config bit positions and the counter mode type.
package pmu_pkg;

  // Register map (word addresses on the configuration port)
  localparam int CTRL     = 'h00;
  localparam int OVF      = 'h01;
  localparam int IRQ_EN   = 'h02;
  localparam int CNT_BASE = 'h10;
  localparam int CFG_BASE = 'h20;
  localparam int SHD_BASE = 'h30;

  // CTRL register bits; snapshot and clear_all are write-1 pulses
  localparam int CTRL_GLOBAL_EN_BIT = 0;
  localparam int CTRL_FREEZE_BIT    = 1;
  localparam int CTRL_SNAPSHOT_BIT  = 2;
  localparam int CTRL_CLEAR_ALL_BIT = 3;

  // Per-counter config register bits (event select occupies the low bits)
  localparam int CFG_MODE_BIT = 8;
  localparam int CFG_EN_BIT   = 9;

  // What a counter does when incremented at its maximum value
  typedef enum logic {
    PMU_WRAP = 1'b0,
    PMU_SAT  = 1'b1
  } pmuMode_e;

endpackage

// File: rtl/pmu_counter.sv
// One event-counter slice: the live count register, wrap/saturate handling
// at the all-ones value and a single-cycle overflow pulse for the top level.
module pmu_counter
  import pmu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clear,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_wdata,
  input  pmuMode_e         i_mode,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);

  logic [CNT_W-1:0] r_count;
  logic             w_atMax;

  assign w_atMax = &r_count;

  // An increment that is overridden by a clear or a software write never happened,
  // so it cannot report an overflow either.
  assign o_ovf   = i_inc & w_atMax & ~i_we & ~i_clear;
  assign o_count = r_count;

  // Count register: clear_all beats a software write, which beats an increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_we) begin
      r_count <= i_wdata;
    end else if (i_inc) begin
      if (!w_atMax) begin
        r_count <= r_count + CNT_W'(1);
      end else if (i_mode == PMU_WRAP) begin
        r_count <= '0;
      end
    end
  end

endmodule

// File: rtl/pmu_multi.sv
// Multi-counter performance-monitor unit: register decode, per-counter config,
// overflow status and interrupt, freeze-on-overflow, snapshot shadows and the
// registered read port. Each counter slice lives in pmu_counter.
module pmu_multi
  import pmu_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 8,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic [CNT_W-1:0]  cfg_rdata,
  output logic              irq_o
);

  localparam int SEL_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

  // Registered state
  logic               r_globalEn;
  logic               r_freeze;
  logic [NUM_CNT-1:0] r_ovf;
  logic [NUM_CNT-1:0] r_irqEn;
  logic [SEL_W-1:0]   r_cfgSel  [NUM_CNT];
  pmuMode_e           r_cfgMode [NUM_CNT];
  logic [NUM_CNT-1:0] r_cfgEn;
  logic [CNT_W-1:0]   r_shadow  [NUM_CNT];
  logic [CNT_W-1:0]   r_rdata;

  // Decode and datapath wires
  logic [3:0]         w_idx;
  logic [ADDR_W-5:0]  w_page;
  logic               w_idxOk;
  logic               w_isCtrl;
  logic               w_isOvf;
  logic               w_isIrqEn;
  logic               w_isCnt;
  logic               w_isCfg;
  logic               w_isShd;
  logic               w_snapshot;
  logic               w_clearAll;
  logic               w_frozen;
  logic [NUM_CNT-1:0] w_w1c;
  logic [NUM_CNT-1:0] w_evtHit;
  logic [NUM_CNT-1:0] w_inc;
  logic [NUM_CNT-1:0] w_cntWe;
  logic [NUM_CNT-1:0] w_ovfPulse;
  logic [CNT_W-1:0]   w_count [NUM_CNT];
  logic [CNT_W-1:0]   w_rdMux;
  logic               w_unusedWdata;

  // Indexed registers live in 16-word pages; the low nibble picks the counter
  assign w_idx   = cfg_addr[3:0];
  assign w_page  = cfg_addr[ADDR_W-1:4];
  assign w_idxOk = int'(w_idx) < NUM_CNT;

  assign w_isCtrl  = (cfg_addr == ADDR_W'(CTRL));
  assign w_isOvf   = (cfg_addr == ADDR_W'(OVF));
  assign w_isIrqEn = (cfg_addr == ADDR_W'(IRQ_EN));
  assign w_isCnt   = (w_page == (ADDR_W-4)'(CNT_BASE >> 4)) && w_idxOk;
  assign w_isCfg   = (w_page == (ADDR_W-4)'(CFG_BASE >> 4)) && w_idxOk;
  assign w_isShd   = (w_page == (ADDR_W-4)'(SHD_BASE >> 4)) && w_idxOk;

  assign w_snapshot = cfg_we & w_isCtrl & cfg_wdata[CTRL_SNAPSHOT_BIT];
  assign w_clearAll = cfg_we & w_isCtrl & cfg_wdata[CTRL_CLEAR_ALL_BIT];
  assign w_w1c      = (cfg_we && w_isOvf) ? cfg_wdata[NUM_CNT-1:0] : '0;
  assign w_frozen   = r_freeze & (|r_ovf);

  // Write-data bits above the widest field are simply not stored anywhere
  assign w_unusedWdata = ^cfg_wdata;

  // Per-counter increment qualification and live-counter write strobes
  always_comb begin
    w_evtHit = '0;
    w_inc    = '0;
    w_cntWe  = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(r_cfgSel[i]) < NUM_EVT) begin
        w_evtHit[i] = evt_i[r_cfgSel[i]];
      end
      w_inc[i]   = r_globalEn & r_cfgEn[i] & w_evtHit[i] & ~w_frozen;
      w_cntWe[i] = cfg_we & w_isCnt & (int'(w_idx) == i);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CNT; g++) begin : gCnt
      pmu_counter #(
        .CNT_W(CNT_W)
      ) uCounter (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_inc[g]),
        .i_clear(w_clearAll),
        .i_we   (w_cntWe[g]),
        .i_wdata(cfg_wdata),
        .i_mode (r_cfgMode[g]),
        .o_count(w_count[g]),
        .o_ovf  (w_ovfPulse[g])
      );
    end
  endgenerate

  // Global control and interrupt-enable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_globalEn <= 1'b0;
      r_freeze   <= 1'b0;
      r_irqEn    <= '0;
    end else begin
      if (cfg_we && w_isCtrl) begin
        r_globalEn <= cfg_wdata[CTRL_GLOBAL_EN_BIT];
        r_freeze   <= cfg_wdata[CTRL_FREEZE_BIT];
      end
      if (cfg_we && w_isIrqEn) begin
        r_irqEn <= cfg_wdata[NUM_CNT-1:0];
      end
    end
  end

  // Overflow status: a fresh overflow wins over a W1C of the same bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
    end else if (w_clearAll) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~w_w1c) | w_ovfPulse;
    end
  end

  // Per-counter config registers; new settings apply from the next cycle
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rst) begin
        r_cfgSel[i]  <= '0;
        r_cfgMode[i] <= PMU_WRAP;
        r_cfgEn[i]   <= 1'b0;
      end else if (cfg_we && w_isCfg && (int'(w_idx) == i)) begin
        r_cfgSel[i]  <= cfg_wdata[SEL_W-1:0];
        r_cfgMode[i] <= pmuMode_e'(cfg_wdata[CFG_MODE_BIT]);
        r_cfgEn[i]   <= cfg_wdata[CFG_EN_BIT];
      end
    end
  end

  // Shadow bank captures the pre-increment, pre-clear live values
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rst) begin
        r_shadow[i] <= '0;
      end else if (w_snapshot) begin
        r_shadow[i] <= w_count[i];
      end
    end
  end

  // Read mux over current (pre-write) register contents; unmapped reads give 0
  always_comb begin
    w_rdMux = '0;
    if (w_isCtrl) begin
      w_rdMux[CTRL_GLOBAL_EN_BIT] = r_globalEn;
      w_rdMux[CTRL_FREEZE_BIT]    = r_freeze;
    end else if (w_isOvf) begin
      w_rdMux[NUM_CNT-1:0] = r_ovf;
    end else if (w_isIrqEn) begin
      w_rdMux[NUM_CNT-1:0] = r_irqEn;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (int'(w_idx) == i) begin
          if (w_isCnt) begin
            w_rdMux = w_count[i];
          end else if (w_isCfg) begin
            w_rdMux[SEL_W-1:0]   = r_cfgSel[i];
            w_rdMux[CFG_MODE_BIT] = r_cfgMode[i];
            w_rdMux[CFG_EN_BIT]   = r_cfgEn[i];
          end else if (w_isShd) begin
            w_rdMux = r_shadow[i];
          end
        end
      end
    end
  end

  // Read data register: loads on a read strobe and holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (cfg_re) begin
      r_rdata <= w_rdMux;
    end
  end

  assign cfg_rdata = r_rdata;
  assign irq_o     = |(r_ovf & r_irqEn);

endmodule

// File: tb/tb_pmu_multi.sv
// Directed bench for pmu_multi. Reads push their expected value into a
// scoreboard queue; a separate monitor pops and compares when read data
// becomes valid, one cycle after the read strobe.
module tb_pmu_multi;

  localparam int NUM_CNT = 4;
  localparam int CNT_W   = 32;
  localparam int NUM_EVT = 8;
  localparam int ADDR_W  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_EVT-1:0] evt_i;
  logic               cfg_we;
  logic               cfg_re;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [CNT_W-1:0]   cfg_wdata;
  logic [CNT_W-1:0]   cfg_rdata;
  logic               irq_o;

  int checkCount = 0;
  int errorCount = 0;

  logic [CNT_W-1:0] expQ[$];
  string            nameQ[$];

  pmu_multi #(
    .NUM_CNT(NUM_CNT),
    .CNT_W  (CNT_W),
    .NUM_EVT(NUM_EVT),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .evt_i    (evt_i),
    .cfg_we   (cfg_we),
    .cfg_re   (cfg_re),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .irq_o    (irq_o)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Global time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [CNT_W-1:0] actual,
                             input logic [CNT_W-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge
  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [7:0] evt,
                               input logic [31:0] expRd, input string name);
    @(negedge clk);
    cfg_we    = we;
    cfg_re    = re;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    evt_i     = evt;
    if (re) begin
      expQ.push_back(expRd);
      nameQ.push_back(name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [7:0] evt);
    applyStimulus(1'b1, 1'b0, addr, data, evt, 32'h0, "");
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] expected, input string name);
    applyStimulus(1'b0, 1'b1, addr, 32'h0, 8'h00, expected, name);
  endtask

  task automatic idle(input logic [7:0] evt, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, evt, 32'h0, "");
    end
  endtask

  // Monitor: read data is compared the cycle after each accepted read strobe
  initial begin
    forever begin
      @(posedge clk);
      if (cfg_re === 1'b1 && rst === 1'b0) begin
        #1;
        if (expQ.size() == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL unexpected read: got 0x%08h expected no read data", cfg_rdata);
        end else begin
          checkOutput(nameQ.pop_front(), cfg_rdata, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] resetAddrs [8];
    resetAddrs = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h13, 8'h20, 8'h30, 8'h33};

    rst       = 1'b1;
    evt_i     = '0;
    cfg_we    = 1'b0;
    cfg_re    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;

    // Reset state
    idle(8'h00, 3);
    checkOutput("reset rdata", cfg_rdata, 32'h0);
    checkOutput("reset irq", {31'b0, irq_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(resetAddrs[i], 32'h0, $sformatf("reset read 0x%02h", resetAddrs[i]));
    end

    // Counter 0 on event 2, ten qualifying cycles with every event line active
    $display("[TB] basic counting");
    wr(8'h00, 32'h1, 8'h00);
    wr(8'h20, 32'h202, 8'h00);
    idle(8'hFF, 10);
    rd(8'h10, 32'd10, "cnt0 after 10 events");
    rd(8'h11, 32'd0, "cnt1 idle");
    rd(8'h12, 32'd0, "cnt2 idle");
    rd(8'h13, 32'd0, "cnt3 idle");
    rd(8'h20, 32'h202, "cfg0 readback");

    // Wrap mode overflow on counter 1 with its interrupt enabled
    $display("[TB] wrap overflow");
    wr(8'h02, 32'h2, 8'h00);
    wr(8'h11, 32'hFFFF_FFFE, 8'h00);
    wr(8'h21, 32'h200, 8'h00);
    idle(8'h01, 1);
    checkOutput("irq before wrap", {31'b0, irq_o}, 32'h0);
    idle(8'h01, 1);
    checkOutput("irq after wrap", {31'b0, irq_o}, 32'h1);
    rd(8'h11, 32'h0, "cnt1 wrapped");
    rd(8'h01, 32'h2, "ovf after wrap");
    wr(8'h01, 32'h2, 8'h00);
    checkOutput("irq after w1c", {31'b0, irq_o}, 32'h0);

    // Saturate mode; W1C collides with another saturated increment
    $display("[TB] saturate overflow");
    wr(8'h11, 32'hFFFF_FFFE, 8'h00);
    wr(8'h21, 32'h300, 8'h00);
    idle(8'h01, 2);
    wr(8'h01, 32'h2, 8'h01);
    rd(8'h11, 32'hFFFF_FFFF, "cnt1 saturated");
    rd(8'h01, 32'h2, "ovf survives w1c");
    checkOutput("irq saturated", {31'b0, irq_o}, 32'h1);
    wr(8'h01, 32'h2, 8'h00);
    wr(8'h21, 32'h0, 8'h00);
    rd(8'h01, 32'h0, "ovf cleared");

    // Freeze on overflow: counter 0 wraps while counter 2 counts event 3
    $display("[TB] freeze on overflow");
    wr(8'h00, 32'h3, 8'h00);
    wr(8'h10, 32'hFFFF_FFFF, 8'h00);
    wr(8'h22, 32'h203, 8'h00);
    idle(8'h0C, 1);
    idle(8'h08, 2);
    rd(8'h12, 32'd1, "cnt2 frozen");
    rd(8'h01, 32'h1, "ovf0 set");
    checkOutput("irq masked ovf0", {31'b0, irq_o}, 32'h0);
    wr(8'h01, 32'h1, 8'h08);
    idle(8'h08, 2);
    rd(8'h12, 32'd3, "cnt2 resumed");
    wr(8'h00, 32'h1, 8'h00);
    wr(8'h22, 32'h0, 8'h00);

    // Snapshot together with clear_all while events are present
    $display("[TB] snapshot and clear_all");
    wr(8'h10, 32'hFFFF_FFFF, 8'h00);
    wr(8'h13, 32'd97, 8'h00);
    wr(8'h23, 32'h204, 8'h00);
    idle(8'h14, 3);
    rd(8'h01, 32'h1, "ovf0 before clear");
    wr(8'h00, 32'hD, 8'h14);
    rd(8'h33, 32'd100, "shd3 pre-clear");
    rd(8'h13, 32'd0, "cnt3 cleared");
    rd(8'h01, 32'h0, "ovf cleared by clear_all");
    rd(8'h30, 32'd2, "shd0 pre-clear");
    rd(8'h31, 32'hFFFF_FFFF, "shd1");
    rd(8'h32, 32'd3, "shd2");
    rd(8'h11, 32'd0, "cnt1 cleared");
    rd(8'h00, 32'h1, "ctrl pulse bits read 0");

    // Write beats increment, unmapped addresses, read-during-write, hold
    $display("[TB] write priority and unmapped");
    wr(8'h10, 32'd5, 8'h04);
    rd(8'h10, 32'd5, "cnt0 write beats inc");
    rd(8'h3F, 32'h0, "unmapped 0x3F");
    rd(8'h14, 32'h0, "cnt index 4");
    wr(8'h14, 32'h55, 8'h00);
    rd(8'h14, 32'h0, "cnt index 4 after write");
    rd(8'h03, 32'h0, "unmapped 0x03");
    applyStimulus(1'b1, 1'b1, 8'h10, 32'd9, 8'h00, 32'd5, "cnt0 read during write");
    rd(8'h10, 32'd9, "cnt0 after write");
    idle(8'h00, 2);
    checkOutput("rdata hold", cfg_rdata, 32'd9);

    // Reset in the middle of operation
    $display("[TB] mid-operation reset");
    @(negedge clk);
    rst = 1'b1;
    idle(8'h04, 2);
    checkOutput("mid reset rdata", cfg_rdata, 32'h0);
    checkOutput("mid reset irq", {31'b0, irq_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(8'h10, 32'h0, "cnt0 after reset");
    rd(8'h00, 32'h0, "ctrl after reset");
    idle(8'h04, 2);
    rd(8'h10, 32'h0, "cnt0 stays 0 after reset");

    idle(8'h00, 3);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
